// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states, frame
// geometry and the default bit-period derivation for a 50 MHz / 115200 link.
package uart_pkg;

  localparam int CLK_FREQ         = 50_000_000;
  localparam int BAUD             = 115_200;
  localparam int DEF_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } rx_state_e;

  // Returns 1 when data plus its even-parity bit contain an odd number of ones.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input. Resets to 1 so an
// idle-high serial line never shows a spurious low right after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver (8N1, LSB first) with a one-entry holding register,
// sticky framing/overrun flags and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err_o;
// without it parity_err_o is tied low.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  input  logic       rd_ack_i,
  input  logic       err_clr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_ready_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rxs_s;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;
  logic              accept_s;
  logic              frame_evt_s;
  logic              par_evt_s;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rx_i),
    .sync_o  (rxs_s)
  );

  // Frame sequencing: start detection, mid-bit sampling and stop-bit check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    accept_s    = 1'b0;
    frame_evt_s = 1'b0;
    par_evt_s   = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        if (rxs_s) state_d = IDLE;
        else       state_d = WAIT_HIGH;
      end
      IDLE: begin
        if (!rxs_s) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs_s) begin
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          // Shifting in from the top leaves the first bit in bit 0 after 8 samples.
          shift_d = {rxs_s, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_evt_s = parity_bad(shift_q, rxs_s);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_s) begin
            accept_s = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_evt_s = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register and sticky flags; an error event beats a same-cycle clear.
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ovr_d   = err_clr_i ? 1'b0 : ovr_q;
    ferr_d  = err_clr_i ? 1'b0 : ferr_q;
    perr_d  = err_clr_i ? 1'b0 : perr_q;
    if (accept_s) begin
      if (!ready_q || rd_ack_i) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_ack_i && ready_q) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end
    if (frame_evt_s) ferr_d = 1'b1;
    else             ferr_d = ferr_d;
    if (par_evt_s)   perr_d = 1'b1;
    else             perr_d = perr_d;
    busy_d = (state_d != IDLE);
  end

  // All receiver state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_HIGH;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_ready_o  = ready_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized bench for uart_rx_core at 16 clocks per bit.
// A frame-level model tracks the holding register and sticky flags.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_i;
  logic       rd_ack_i;
  logic       err_clr_i;
  logic [7:0] rx_data_o;
  logic       rx_ready_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic       m_ready, m_ferr, m_ovr, m_perr;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .rd_ack_i     (rd_ack_i),
    .err_clr_i    (err_clr_i),
    .rx_data_o    (rx_data_o),
    .rx_ready_o   (rx_ready_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    @(negedge clk);
    chk({tag, "/data"},  rx_data_o, m_data);
    chk({tag, "/ready"}, {7'd0, rx_ready_o},   {7'd0, m_ready});
    chk({tag, "/ferr"},  {7'd0, frame_err_o},  {7'd0, m_ferr});
    chk({tag, "/ovr"},   {7'd0, overrun_o},    {7'd0, m_ovr});
    chk({tag, "/perr"},  {7'd0, parity_err_o}, {7'd0, m_perr});
    chk({tag, "/busy"},  {7'd0, busy_o},       {7'd0, exp_busy});
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Effect of one complete frame on the receiver's visible state.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
    if ((^d) != par) m_perr = 1'b1;
`endif
    if (!stop) begin
      m_ferr = 1'b1;
    end else if (!m_ready) begin
      m_data  = d;
      m_ready = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Drives one serial frame; abort_bit >= 0 pulses reset mid-way through that data bit.
  task automatic send(input logic [7:0] d, input logic stop, input logic par,
                      input int abort_bit, input int gap);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(par);
`endif
    bits.push_back(stop);
    for (int j = 0; j < bits.size(); j++) begin
      rx_i = bits[j];
      for (int c = 0; c < CPB; c++) begin
        if (abort_bit >= 0 && j == abort_bit + 1 && c == CPB / 2) begin
          reset = 1'b0;
          tick();
          reset = 1'b1;
          model_reset();
          check_all("rst_mid", 1'b1);
        end else begin
          tick();
        end
      end
    end
    rx_i = 1'b1;
    if (abort_bit < 0) model_frame(d, stop, par);
    repeat (gap) tick();
  endtask

  task automatic pulse_ack();
    rd_ack_i = 1'b1;
    tick();
    rd_ack_i = 1'b0;
    if (m_ready) m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;

    reset     = 1'b0;
    rx_i      = 1'b1;
    rd_ack_i  = 1'b0;
    err_clr_i = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all("reset", 1'b1);
    reset = 1'b1;
    repeat (10 * CPB + 8) tick();
    check_all("idle", 1'b0);

    // Plain 0x55 frame.
    send(8'h55, 1'b1, ^8'h55, -1, 6);
    check_all("byte55", 1'b0);

    // Framing error, then a good frame.
    pulse_ack();
    send(8'hA3, 1'b0, ^8'hA3, -1, 6);
    check_all("ferrA3", 1'b0);
    send(8'h3C, 1'b1, ^8'h3C, -1, 6);
    check_all("byte3C", 1'b0);

    // Short low glitch on an idle line must not start a frame.
    pulse_ack();
    pulse_clr();
    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (30) tick();
    check_all("glitch", 1'b0);

    // Overrun: second byte dropped, then ack and clear.
    send(8'h12, 1'b1, ^8'h12, -1, 6);
    send(8'h34, 1'b1, ^8'h34, -1, 6);
    check_all("overrun", 1'b0);
    pulse_ack();
    check_all("ack", 1'b0);
    pulse_clr();
    check_all("clr", 1'b0);

    // Reset during bit 3 of an all-ones frame, then a fresh byte.
    send(8'hFF, 1'b1, ^8'hFF, 3, 6);
    check_all("after_rst", 1'b0);
    send(8'h81, 1'b1, ^8'h81, -1, 6);
    check_all("byte81", 1'b0);

`ifdef UART_RX_PARITY_EN
    pulse_ack();
    send(8'h07, 1'b1, 1'b0, -1, 6);
    check_all("par_bad", 1'b0);
    pulse_ack();
    pulse_clr();
    send(8'h07, 1'b1, 1'b1, -1, 6);
    check_all("par_ok", 1'b0);
`endif

    // Randomized frames with occasional bad stop/parity bits, acks and clears.
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      send(d, stop, par, -1, 6);
      check_all("rand", 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_ack();
      if ($urandom_range(0, 2) == 0) pulse_clr();
      tick();
      check_all("rand_gap", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
